// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer placing two requesters (pipeline port 0, loader port 1)
// onto a single-ported data memory, with registered command lines and a one-cycle ack.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clkIn,
    input  logic              resetIn,
    input  logic              Req0In,
    input  logic              Wr0In,
    input  logic [ADDR_W-1:0] Addr0In,
    input  logic [DATA_W-1:0] Data0In,
    output logic              Ack0Out,
    output logic [DATA_W-1:0] RData0Out,
    output logic              Err0Out,
    output logic              Stall0Out,
    input  logic              Req1In,
    input  logic              Wr1In,
    input  logic [ADDR_W-1:0] Addr1In,
    input  logic [DATA_W-1:0] Data1In,
    output logic              Ack1Out,
    output logic [DATA_W-1:0] RData1Out,
    output logic              Err1Out,
    output logic [ADDR_W-1:0] MemAddrOut,
    output logic [DATA_W-1:0] MemDataOut,
    output logic              MemReadOut,
    output logic              MemWriteOut,
    input  logic [DATA_W-1:0] MemDataIn
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic elig0, elig1, gnt_valid, gnt_port;
    logic acc, in_range, rd_ok0, rd_ok1;

    // A port in its own ack cycle is not eligible, so a held request alternates.
    assign elig0     = Req0In & (state_q != ACC0);
    assign elig1     = Req1In & (state_q != ACC1);
    assign gnt_valid = elig0 | elig1;
    assign gnt_port  = (elig0 & elig1) ? ~last_gnt_q : elig1;

    always_comb begin
        state_d    = IDLE;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q;
        if (gnt_valid) begin
            state_d    = gnt_port ? ACC1 : ACC0;
            last_gnt_d = gnt_port;
            addr_d     = gnt_port ? Addr1In : Addr0In;
            data_d     = gnt_port ? Data1In : Data0In;
            wr_d       = gnt_port ? Wr1In   : Wr0In;
        end
    end

    assign acc      = (state_q == ACC0) | (state_q == ACC1);
    assign in_range = addr_q < DEPTH_A;
    assign rd_ok0   = (state_q == ACC0) & ~wr_q & in_range;
    assign rd_ok1   = (state_q == ACC1) & ~wr_q & in_range;

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            if (rd_ok0) rdata0_q <= MemDataIn;
            if (rd_ok1) rdata1_q <= MemDataIn;
        end
    end

    // Command lines come straight from the grant latch; enables are gated by state.
    assign MemAddrOut  = addr_q;
    assign MemDataOut  = data_q;
    assign MemReadOut  = acc & ~wr_q & in_range;
    assign MemWriteOut = acc &  wr_q & in_range;

    assign Ack0Out   = (state_q == ACC0);
    assign Ack1Out   = (state_q == ACC1);
    assign Err0Out   = (state_q == ACC0) & ~in_range;
    assign Err1Out   = (state_q == ACC1) & ~in_range;
    assign Stall0Out = Req0In & ~Ack0Out;
    assign RData0Out = rd_ok0 ? MemDataIn : rdata0_q;
    assign RData1Out = rd_ok1 ? MemDataIn : rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected acks, a negedge monitor
// pops and checks them; a small array stands in for the data memory.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
    logic [31:0] addr0 = '0, data0 = '0, addr1 = '0, data1 = '0;
    logic        ack0, ack1, err0, err1, stall0, mrd, mwr;
    logic [31:0] rdata0, rdata1, maddr, mdata, mem_rdata;
    logic [31:0] mem [0:31];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          err;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(32)) dut (
        .clkIn(clk), .resetIn(rst),
        .Req0In(req0), .Wr0In(wr0), .Addr0In(addr0), .Data0In(data0),
        .Ack0Out(ack0), .RData0Out(rdata0), .Err0Out(err0), .Stall0Out(stall0),
        .Req1In(req1), .Wr1In(wr1), .Addr1In(addr1), .Data1In(data1),
        .Ack1Out(ack1), .RData1Out(rdata1), .Err1Out(err1),
        .MemAddrOut(maddr), .MemDataOut(mdata), .MemReadOut(mrd), .MemWriteOut(mwr),
        .MemDataIn(mem_rdata)
    );

    // Data memory: combinational read, write on the clock edge.
    always_comb mem_rdata = (maddr < 32) ? mem[maddr[4:0]] : 32'h0;
    always @(posedge clk) if (mwr) mem[maddr[4:0]] <= mdata;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(int p, bit w, logic [31:0] a, logic [31:0] d, bit er);
        exp_t x;
        x.port = p; x.wr = w; x.addr = a; x.data = d; x.err = er;
        return x;
    endfunction

    // Monitor: every ack is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (ack0 || ack1)) begin
            check(!(ack0 && ack1), "one_ack", {30'd0, ack1, ack0}, 32'd1);
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                e = sb.pop_front();
                check((ack1 ? 1 : 0) == e.port, "ack_port", {31'd0, ack1}, e.port);
                check((ack1 ? err1 : err0) == e.err, "err", {31'd0, ack1 ? err1 : err0},
                      {31'd0, e.err});
                check(maddr == e.addr, "mem_addr", maddr, e.addr);
                if (e.err)
                    check(!mrd && !mwr, "oor_no_access", {30'd0, mrd, mwr}, 32'd0);
                else if (e.wr)
                    check(mwr && !mrd && mdata == e.data, "write_cmd", mdata, e.data);
                else
                    check(mrd && !mwr && (ack1 ? rdata1 : rdata0) == e.data, "read_data",
                          ack1 ? rdata1 : rdata0, e.data);
                $display("[TB] ack port%0d %s addr=%0d data=0x%08h err=%0d", e.port,
                         e.wr ? "WR" : "RD", e.addr, e.data, e.err);
            end
        end
    end

    task automatic rst_pulse();
        @(posedge clk); #1;
        rst = 1; req0 = 0; req1 = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic set_port(int p, bit w, logic [31:0] a, logic [31:0] d);
        if (p == 0) begin req0 = 1; wr0 = w; addr0 = a; data0 = d; end
        else        begin req1 = 1; wr1 = w; addr1 = a; data1 = d; end
    endtask

    // Uncontended access: ack expected on the second negedge after the request.
    task automatic single(int p, bit w, logic [31:0] a, logic [31:0] d, bit er);
        int  n = 0;
        bit  got = 0;
        logic a_s;
        sb.push_back(mk(p, w, a, d, er));
        @(posedge clk); #1;
        set_port(p, w, a, d);
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            a_s = (p == 0) ? ack0 : ack1;
            if (a_s) got = 1;
            if (p == 0) check(stall0 == !a_s, "stall0", {31'd0, stall0}, {31'd0, !a_s});
        end
        check(got && n == 2, "latency", n, 32'd2);
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
    endtask

    // Simultaneous requests; first = port expected to win. Acks must be adjacent.
    task automatic pair(bit w0, logic [31:0] a0, logic [31:0] d0,
                        bit w1, logic [31:0] a1, logic [31:0] d1, int first);
        int n = 0, t0 = 0, t1 = 0;
        if (first == 0) begin
            sb.push_back(mk(0, w0, a0, d0, 0)); sb.push_back(mk(1, w1, a1, d1, 0));
        end else begin
            sb.push_back(mk(1, w1, a1, d1, 0)); sb.push_back(mk(0, w0, a0, d0, 0));
        end
        @(posedge clk); #1;
        set_port(0, w0, a0, d0);
        set_port(1, w1, a1, d1);
        while ((t0 == 0 || t1 == 0) && n < 10) begin
            @(negedge clk);
            n++;
            if (ack0 && t0 == 0) begin t0 = n; req0 = 0; end
            if (ack1 && t1 == 0) begin t1 = n; req1 = 0; end
        end
        check((first == 0 ? t0 : t1) == 2, "pair_first", first == 0 ? t0 : t1, 32'd2);
        check((first == 0 ? t1 : t0) == 3, "pair_b2b", first == 0 ? t1 : t0, 32'd3);
        req0 = 0; req1 = 0;
    endtask

    initial begin
        int n, acks, last, prev;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;

        repeat (2) @(posedge clk);
        #1 rst = 0;
        check(!ack0 && !ack1 && !mrd && !mwr, "rst_ctrl", {28'd0, ack0, ack1, mrd, mwr}, 0);
        check(maddr == 0 && mdata == 0, "rst_mem_bus", maddr | mdata, 32'd0);
        check(rdata0 == 0 && rdata1 == 0, "rst_rdata", rdata0 | rdata1, 32'd0);
        check(!stall0 && !err0 && !err1, "rst_flags", {29'd0, stall0, err0, err1}, 0);

        // Reset in the middle of a write cancels it.
        @(posedge clk); #1;
        set_port(0, 1, 32'd5, 32'h0000_DEAD);
        @(posedge clk); #1;
        check(mwr == 1 && ack0 == 1, "mid_write_active", {30'd0, mwr, ack0}, 32'd3);
        #1 rst = 1;
        #1;
        check(mwr == 0 && ack0 == 0, "rst_drops_write", {30'd0, mwr, ack0}, 32'd0);
        req0 = 0;
        @(posedge clk); #1;
        rst = 0;
        single(0, 0, 32'd5, 32'hA000_0005, 0);

        single(0, 1, 32'd3, 32'h1234_5678, 0);
        single(0, 0, 32'd3, 32'h1234_5678, 0);
        @(negedge clk);
        check(rdata0 == 32'h1234_5678, "rdata0_held", rdata0, 32'h1234_5678);

        // Round robin: port 0 wins first after reset; a port-0 access then hands priority to 1.
        rst_pulse();
        pair(1, 32'd10, 32'h1111, 1, 32'd11, 32'h2222, 0);
        single(0, 0, 32'd10, 32'h1111, 0);
        pair(0, 32'd10, 32'h1111, 0, 32'd11, 32'h2222, 1);
        single(1, 0, 32'd11, 32'h2222, 0);

        // Both held: strict alternation starting with port 0, no idle cycles.
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(0, 0, 32'd3, 32'h1234_5678, 0));
            sb.push_back(mk(1, 0, 32'd11, 32'h2222, 0));
        end
        @(posedge clk); #1;
        set_port(0, 0, 32'd3, 0);
        set_port(1, 0, 32'd11, 0);
        n = 0; acks = 0; last = 0;
        while (acks < 8 && n < 20) begin
            @(negedge clk);
            n++;
            if (ack0 || ack1) begin acks++; last = n; end
            if (acks == 8) begin req0 = 0; req1 = 0; end
        end
        req0 = 0; req1 = 0;
        check(acks == 8 && last == 9, "hold_no_idle", last, 32'd9);

        // Out-of-range write on port 1 must not touch address 0.
        single(1, 1, 32'd32, 32'h0000_BEEF, 1);
        single(0, 0, 32'd0, 32'hA000_0000, 0);

        // Port 0 holding its request gets one access every other cycle.
        for (int i = 0; i < 3; i++) sb.push_back(mk(0, 0, 32'd3, 32'h1234_5678, 0));
        @(posedge clk); #1;
        set_port(0, 0, 32'd3, 0);
        n = 0; acks = 0; prev = 0;
        while (acks < 3 && n < 20) begin
            @(negedge clk);
            n++;
            if (ack0) begin
                acks++;
                if (acks > 1) check(n - prev == 2, "hold0_spacing", n - prev, 32'd2);
                prev = n;
                if (acks == 3) req0 = 0;
            end
        end
        req0 = 0;
        check(acks == 3, "hold0_count", acks, 32'd3);

        repeat (3) @(posedge clk);
        check(sb.size() == 0, "sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got 0x%08h, expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "timeout");
    end
endmodule
